// File: rtl/digital.sv
// Six-digit multiplexed 7-segment driver: scans one digit per SCAN_DIV clocks and drives active-low seg/sel.
// Define DIGITAL_HEX_EN to show codes 10..15 as A,b,C,d,E,F; otherwise those codes blank the segments.
module digital #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] data1,
    input  logic [3:0] data2,
    input  logic [3:0] data3,
    input  logic [3:0] data4,
    input  logic [3:0] data5,
    input  logic [3:0] data6,
    input  logic [5:0] dp,
    output logic [7:0] seg,
    output logic [5:0] sel
);

    localparam int              CW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [2:0]      IDX_LAST = 3'd5;
    localparam logic [7:0]      SEG_OFF  = 8'hFF;
    localparam logic [5:0]      SEL_OFF  = 6'h3F;

    // Active-low g..a pattern for one nibble.
    function automatic logic [6:0] decode7(input logic [3:0] n);
        logic [6:0] s;
        s = 7'h7F;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
`ifdef DIGITAL_HEX_EN
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
`else
            default: s = 7'h7F;
`endif
        endcase
        return s;
    endfunction

    logic [CW-1:0] cnt_reg;
    logic [2:0]    idx_reg;
    logic [2:0]    idx_next;
    logic [7:0]    seg_reg;
    logic [7:0]    seg_next;
    logic [5:0]    sel_reg;
    logic [5:0]    sel_next;
    logic          tick;

    logic [23:0]   data_all;
    logic [3:0]    nibble [6];
    logic [7:0]    code   [6];

    assign data_all = {data6, data5, data4, data3, data2, data1};

    // Full seg byte for every digit, so the tick edge just picks one.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_digit
            assign nibble[gi] = data_all[gi*4 +: 4];
            assign code[gi]   = {~dp[gi], decode7(nibble[gi])};
        end
    endgenerate

    always_comb begin
        tick     = 1'b0;
        idx_next = 3'd0;
        sel_next = SEL_OFF;
        seg_next = SEG_OFF;

        tick     = (cnt_reg == CNT_LAST);
        idx_next = (idx_reg == IDX_LAST) ? 3'd0 : idx_reg + 3'd1;
        sel_next = ~(6'b000001 << idx_next);
        seg_next = code[idx_next];
    end

    // Index resets to the last digit so the first tick lands on digit 1.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            cnt_reg <= '0;
            idx_reg <= IDX_LAST;
            seg_reg <= SEG_OFF;
            sel_reg <= SEL_OFF;
        end else if (tick) begin
            cnt_reg <= '0;
            idx_reg <= idx_next;
            seg_reg <= seg_next;
            sel_reg <= sel_next;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign seg = seg_reg;
    assign sel = sel_reg;

endmodule

// File: tb/tb_digital.sv
// Scoreboard bench for digital with SCAN_DIV = 4: stimulus queues expected (sel, seg) pairs, a monitor
// pops one on every output change and also checks the dwell between changes.
module tb_digital;

    localparam int SCAN_DIV = 4;
`ifdef DIGITAL_HEX_EN
    localparam logic [7:0] SEG_A = 8'h88;
`else
    localparam logic [7:0] SEG_A = 8'hFF;
`endif

    logic       clk;
    logic       rstn;
    logic [3:0] data1, data2, data3, data4, data5, data6;
    logic [5:0] dp;
    logic [7:0] seg;
    logic [5:0] sel;

    typedef struct {
        logic [5:0] sel;
        logic [7:0] seg;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    digital #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .data1 (data1),
        .data2 (data2),
        .data3 (data3),
        .data4 (data4),
        .data5 (data5),
        .data6 (data6),
        .dp    (dp),
        .seg   (seg),
        .sel   (sel)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end else begin
            $display("ok   %s: %0h", name, got);
        end
    endtask

    task automatic push_exp(input logic [5:0] s, input logic [7:0] g);
        exp_t e;
        e.sel = s;
        e.seg = g;
        q.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", q.size());
            q.delete();
        end
    endtask

    task automatic release_and_check(input logic [5:0] first_sel);
        @(negedge clk);
        #1 rstn = 1'b0;
        for (int k = 0; k < SCAN_DIV - 1; k++) begin
            @(negedge clk);
            check("off_sel", 32'(sel), 32'h3F);
            check("off_seg", 32'(seg), 32'hFF);
        end
        @(negedge clk);
        check("first_tick_sel", 32'(sel), 32'(first_sel));
    endtask

    // Monitor: every change of {sel, seg} outside reset must match the queue head.
    initial begin
        logic [13:0] prev;
        int          hold;
        bit          armed;
        exp_t        e;
        prev  = {6'h3F, 8'hFF};
        hold  = 0;
        armed = 1'b0;
        forever begin
            @(negedge clk);
            if (rstn) begin
                prev  = {6'h3F, 8'hFF};
                hold  = 0;
                armed = 1'b0;
            end else begin
                hold++;
                if ({sel, seg} !== prev) begin
                    if (q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_change: got sel=%h seg=%h want no change", sel, seg);
                    end else begin
                        e = q.pop_front();
                        check("scan_sel", 32'(sel), 32'(e.sel));
                        check("scan_seg", 32'(seg), 32'(e.seg));
                    end
                    if (armed) check("dwell", 32'(hold), 32'(SCAN_DIV));
                    armed = 1'b1;
                    hold  = 0;
                    prev  = {sel, seg};
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        rstn  = 1'b1;
        data1 = 4'd1; data2 = 4'd2; data3 = 4'd3;
        data4 = 4'd4; data5 = 4'd5; data6 = 4'd6;
        dp    = 6'b101011;
        repeat (2) @(negedge clk);
        check("reset_seg", 32'(seg), 32'hFF);
        check("reset_sel", 32'(sel), 32'h3F);

        // Full scan plus wrap, stopping on the second visit to digit 3.
        push_exp(6'h3E, 8'h79); push_exp(6'h3D, 8'h24); push_exp(6'h3B, 8'hB0);
        push_exp(6'h37, 8'h19); push_exp(6'h2F, 8'h92); push_exp(6'h1F, 8'h02);
        push_exp(6'h3E, 8'h79); push_exp(6'h3D, 8'h24); push_exp(6'h3B, 8'hB0);
        release_and_check(6'h3E);
        drain(100);

        // data3 changes while digit 3 is lit: only the next visit shows 8.
        data3 = 4'd8;
        push_exp(6'h37, 8'h19); push_exp(6'h2F, 8'h92); push_exp(6'h1F, 8'h02);
        push_exp(6'h3E, 8'h79); push_exp(6'h3D, 8'h24); push_exp(6'h3B, 8'h80);
        drain(100);

        // Code A on digit 1, decimal points off.
        data1 = 4'hA;
        dp    = 6'b000000;
        push_exp(6'h37, 8'h99); push_exp(6'h2F, 8'h92); push_exp(6'h1F, 8'h82);
        push_exp(6'h3E, SEG_A); push_exp(6'h3D, 8'hA4); push_exp(6'h3B, 8'h80);
        push_exp(6'h37, 8'h99);
        drain(100);

        // Reset while digit 4 is lit.
        @(posedge clk);
        #5 rstn = 1'b1;
        #1;
        check("midreset_seg", 32'(seg), 32'hFF);
        check("midreset_sel", 32'(sel), 32'h3F);
        repeat (2) @(negedge clk);
        push_exp(6'h3E, SEG_A); push_exp(6'h3D, 8'hA4);
        release_and_check(6'h3E);
        drain(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
